// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [3:0]  BCD_MAX    = 4'd9;
   localparam int unsigned PRESC_W    = 16;

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// Single BCD counter cell: counts 0..9, wraps to 0 and reports carry when
// incremented at 9.
module bcd_digit
   import bcd_stopwatch_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_en,
   input  logic       clr,
   output logic [3:0] value,
   output logic       carry_out
);

   // Digit register: clear has priority over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc_en) begin
         value <= (value == BCD_MAX) ? '0 : value + 4'd1;
      end
   end

   // Carry is combinational so a full 9..9 ripple settles before one edge.
   always_comb begin
      carry_out = inc_en && (value == BCD_MAX);
   end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: IDLE/RUN/PAUSE control, prescaled tick,
// sticky overflow and lap capture.
module bcd_stopwatch_ctrl
   import bcd_stopwatch_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 10
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] digits,
   output logic        running,
   output logic        overflow,
   output logic [15:0] lap_digits,
   output logic        lap_valid
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   state_t             state;
   state_t             state_nxt;
   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic               tick_apply;
   logic               wrap;
   logic               lap_take;

   // Tick fires on the last prescaler count in RUN; clear discards it.
   always_comb begin
      tick       = (state == RUN) && (presc == PRESC_LAST);
      tick_apply = tick && !clear;
      lap_take   = lap && !clear && (state != IDLE);
   end

   // Digit chain: each stage increments when all lower stages wrap.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      logic inc;
      logic co;
      if (g == 0) begin : g_first
         assign inc = tick_apply;
      end else begin : g_next
         assign inc = g_dig[g-1].co;
      end
      bcd_digit u_digit (
         .clk       (clk),
         .rst       (rst),
         .inc_en    (inc),
         .clr       (clear),
         .value     (digits[4*g +: 4]),
         .carry_out (co)
      );
   end

   assign wrap = g_dig[NUM_DIGITS-1].co;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic with clear > stop > start priority.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else if (stop) begin
         if (state == RUN) begin
            state_nxt = PAUSE;
         end
      end else if (start && (state != RUN)) begin
         state_nxt = RUN;
      end
   end

   // FSM outputs decoded from the registered state.
   always_comb begin
      running = (state == RUN);
   end

   // Prescaler: counts in RUN, holds in PAUSE, zero in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else begin
         case (state)
            RUN:     presc <= tick ? '0 : presc + PRESC_W'(1);
            IDLE:    presc <= '0;
            default: presc <= presc;
         endcase
      end
   end

   // Sticky overflow, set when the top digit carries out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
      end else if (wrap) begin
         overflow <= 1'b1;
      end
   end

   // Lap capture of the pre-edge count with a one-cycle valid pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lap_digits <= '0;
         lap_valid  <= 1'b0;
      end else begin
         lap_valid <= lap_take;
         if (lap_take) begin
            lap_digits <= digits;
         end
      end
   end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10: clock cycles per count increment, legal range 2..65535.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-low.
REQ-004 Port start, input, 1: level-sampled command to enter or resume counting.
REQ-005 Port stop, input, 1: level-sampled command to pause counting.
REQ-006 Port clear, input, 1: level-sampled command to return to idle with a zero count.
REQ-007 Port lap, input, 1: level-sampled command to capture the current count.
REQ-008 Port digits, output, 16: four BCD digits, [3:0] least significant; each nibble always 0..9.
REQ-009 Port running, output, 1: high while in RUN.
REQ-010 Port overflow, output, 1: sticky flag, set on wrap 9999->0000.
REQ-011 Port lap_digits, output, 16: count captured by the last accepted lap.
REQ-012 Port lap_valid, output, 1: one-cycle pulse when lap_digits is updated.

Function
REQ-013 FSM states SHALL be IDLE, RUN and PAUSE; running = (state==RUN), registered.
REQ-014 Command priority SHALL be clear > stop > start when several commands are high in one cycle.
REQ-015 clear in any state -> IDLE next edge: digits=0, prescaler=0, overflow=0; lap_digits unchanged.
REQ-016 start in IDLE or PAUSE (no clear/stop) -> RUN next edge; start in RUN is ignored.
REQ-017 stop in RUN (no clear) -> PAUSE next edge; stop in IDLE or PAUSE is ignored.
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 only while in RUN; it wraps to 0 and asserts an internal tick in the cycle it equals TICK_DIV-1.
REQ-019 Prescaler SHALL hold its value in PAUSE (resume continues the partial period) and SHALL be 0 in IDLE.
REQ-020 On tick, digit0 increments mod 10; digit n increments only when digits 0..n-1 are all 9; the whole carry ripple SHALL complete in one edge (9->0 carries, no intermediate non-BCD values).
REQ-021 A tick at 9999 SHALL produce 0000 and set overflow; overflow stays set until clear or reset, and counting continues.
REQ-022 A tick coincident with stop SHALL still be applied; the increment and the transition to PAUSE occur on the same edge.
REQ-023 A tick coincident with clear SHALL be discarded; clear wins.
REQ-024 First increment SHALL occur exactly TICK_DIV edges after the edge that entered RUN from IDLE.
REQ-025 lap in RUN or PAUSE (no clear) SHALL load lap_digits with the digits value present before that edge and pulse lap_valid for one cycle.
REQ-026 A lap coincident with a tick SHALL capture the pre-increment value.
REQ-027 lap in IDLE or with clear SHALL be ignored; lap_valid stays low.
REQ-028 lap held high for N cycles in RUN/PAUSE SHALL produce N captures and N consecutive lap_valid cycles.

Reset
REQ-029 Asserting rst low SHALL immediately set state=IDLE, prescaler=0, digits=0, lap_digits=0, running=0, overflow=0, lap_valid=0, regardless of clk.
REQ-030 A reset asserted mid-count SHALL discard the partial prescaler period; after release, the first edge with start high enters RUN.
REQ-031 Command inputs SHALL be ignored while rst is low.

Structure
REQ-032 A shared package SHALL hold the state type (IDLE/RUN/PAUSE), the NUM_DIGITS=4 constant, the BCD_MAX=9 constant and the prescaler width constant (16).
REQ-033 A per-digit sub-module bcd_digit (4-bit mod-10 cell with inc_en, clr, carry_out) SHALL be instantiated four times, chained via carry.
REQ-034 The FSM, prescaler and lap register SHALL reside in bcd_stopwatch_ctrl itself.

Verification (TICK_DIV=4)
REQ-035 Reset, start high 1 cycle -> running=1 next edge; digits=0001 after 4 edges; 0010 after 40 edges.
REQ-036 Run to 0099, let one tick elapse -> digits=0100 in one edge; run from 9998 for 2 ticks -> 9999, then 0000 with overflow=1; overflow persists until clear.
REQ-037 stop with 2 prescaler cycles elapsed, wait 20 cycles, start -> digits unchanged during PAUSE; next increment 2 edges after resume.
REQ-038 lap on the tick edge that takes 0007->0008 -> lap_digits=0007, lap_valid high exactly 1 cycle; lap in IDLE -> no pulse.
REQ-039 clear, stop and start all high in RUN at 0042 -> IDLE, digits=0000, running=0, overflow=0.
REQ-040 rst driven low mid-clock-period at 0315 -> all outputs 0 immediately, without waiting for a clock edge; after release, outputs hold 0 until start.
